// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared types for the iterative multiply/divide unit.
//   md_op_t    : operation codes presented on muldiv_unit.op
//   md_state_t : sequencer states (IDLE, RUN, FIX)
//   is_muldiv  : true for the multi-cycle operations (MULT/MULTU/DIV/DIVU)
//   is_signed  : true for the signed multi-cycle operations (MULT/DIV)
// -----------------------------------------------------------------------------
package muldiv_pkg;

    typedef enum logic [2:0] {
        MD_NOP   = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } md_state_t;

    function automatic logic is_muldiv(input md_op_t op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_signed(input md_op_t op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// -----------------------------------------------------------------------------
// muldiv_step
// One radix-2 iteration of the multiply/divide datapath (combinational).
//   i_div : 1 = restoring-divide step, 0 = shift-add multiply step
//   i_acc : upper working register (partial product high half / remainder)
//   i_q   : lower working register (multiplier bits / dividend-then-quotient)
//   i_m   : multiplicand (multiply) or divisor (divide), unsigned magnitude
//   o_acc : next upper working register
//   o_q   : next lower working register
// -----------------------------------------------------------------------------
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             i_div,
    input  logic [WIDTH-1:0] i_acc,
    input  logic [WIDTH-1:0] i_q,
    input  logic [WIDTH-1:0] i_m,
    output logic [WIDTH-1:0] o_acc,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_shift;
    logic             w_ge;
    logic [WIDTH-1:0] w_sub;

    always_comb begin
        // Multiply: add multiplicand when the current multiplier bit is set,
        // then shift the (WIDTH+1)-bit sum and the multiplier right together.
        w_sum   = {1'b0, i_acc} + (i_q[0] ? {1'b0, i_m} : '0);
        // Divide: bring the next dividend bit into the remainder. The trial
        // difference always fits WIDTH bits when it is taken, since the
        // remainder stays below the divisor.
        w_shift = {i_acc, i_q[WIDTH-1]};
        w_ge    = (w_shift >= {1'b0, i_m});
        w_sub   = w_shift[WIDTH-1:0] - i_m;

        if (i_div) begin
            o_acc = w_ge ? w_sub : w_shift[WIDTH-1:0];
            o_q   = {i_q[WIDTH-2:0], w_ge};
        end else begin
            o_acc = w_sum[WIDTH:1];
            o_q   = {w_sum[0], i_q[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
// Iterative multiply/divide unit with architectural HI/LO registers.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset, clears all state
//   start : issue op with operands a/b (taken only when idle and not flushed)
//   op    : operation code (md_op_t)
//   a, b  : rs / rt operands
//   flush : abort an in-flight op, suppress a same-cycle start
//   busy  : multi-cycle op in flight
//   done  : one-cycle pulse once HI/LO hold a new mul/div result
//   hi,lo : HI / LO registers
// Multi-cycle ops run on magnitudes for WIDTH cycles, then one FIX cycle
// applies two's-complement sign correction and writes HI/LO.
// -----------------------------------------------------------------------------
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  md_op_t           op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    md_state_t          r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   r_m;
    logic               r_div;
    logic               r_neg_res;
    logic               r_neg_rem;
    logic               r_dz;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_busy;
    logic               r_done;

    logic               w_accept;
    logic               w_sgn;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH-1:0]   w_step_acc;
    logic [WIDTH-1:0]   w_step_q;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_hi_res;
    logic [WIDTH-1:0]   w_lo_res;

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v, input logic en);
        return en ? -v : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v, input logic en);
        return en ? -v : v;
    endfunction

    assign w_accept = start && !flush && (r_state == IDLE);
    assign w_sgn    = is_signed(op);
    assign w_abs_a  = neg_w(a, w_sgn && a[WIDTH-1]);
    assign w_abs_b  = neg_w(b, w_sgn && b[WIDTH-1]);

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .i_div (r_div),
        .i_acc (r_acc),
        .i_q   (r_q),
        .i_m   (r_m),
        .o_acc (w_step_acc),
        .o_q   (w_step_q)
    );

    // Sign correction evaluated during FIX. Divide-by-zero forces an all-ones
    // quotient; the remainder path already reproduces the dividend because
    // negating abs(a) restores a (including the most-negative value).
    always_comb begin
        w_prod   = neg_2w({r_acc, r_q}, r_neg_res);
        w_hi_res = w_prod[2*WIDTH-1:WIDTH];
        w_lo_res = w_prod[WIDTH-1:0];
        if (r_div) begin
            w_hi_res = neg_w(r_acc, r_neg_rem);
            w_lo_res = r_dz ? '1 : neg_w(r_q, r_neg_res);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_q       <= '0;
            r_m       <= '0;
            r_div     <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_dz      <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (is_muldiv(op)) begin
                            r_div     <= (op == MD_DIV) || (op == MD_DIVU);
                            r_acc     <= '0;
                            // Divide keeps the dividend in r_q and the divisor
                            // in r_m; multiply keeps the multiplier in r_q.
                            r_q       <= ((op == MD_DIV) || (op == MD_DIVU)) ? w_abs_a : w_abs_b;
                            r_m       <= ((op == MD_DIV) || (op == MD_DIVU)) ? w_abs_b : w_abs_a;
                            r_neg_res <= w_sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
                            r_neg_rem <= w_sgn && a[WIDTH-1];
                            r_dz      <= (b == '0);
                            r_cnt     <= '0;
                            r_busy    <= 1'b1;
                            r_state   <= RUN;
                        end else if (op == MD_MTHI) begin
                            r_hi <= a;
                        end else if (op == MD_MTLO) begin
                            r_lo <= a;
                        end
                    end
                end
                RUN: begin
                    if (flush) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_acc <= w_step_acc;
                        r_q   <= w_step_q;
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == CNT_LAST) begin
                            r_state <= FIX;
                        end
                    end
                end
                FIX: begin
                    if (!flush) begin
                        r_hi   <= w_hi_res;
                        r_lo   <= w_lo_res;
                        r_done <= 1'b1;
                    end
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
// Self-checking bench for muldiv_unit (WIDTH=32): directed cases plus a
// randomized mix, checked against a plain-arithmetic HI/LO reference model.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         flush;
    md_op_t       op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int           n_tests = 0;
    int           n_fail  = 0;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Architectural effect of one op on the model HI/LO pair.
    function automatic void model(input md_op_t o, input logic [31:0] x, input logic [31:0] y);
        longint      sx;
        longint      sy;
        longint      q;
        longint      r;
        logic [63:0] p;
        sx = $signed(x);
        sy = $signed(y);
        case (o)
            MD_MULT: begin
                p = sx * sy;
                {m_hi, m_lo} = p;
            end
            MD_MULTU: begin
                p = {32'b0, x} * {32'b0, y};
                {m_hi, m_lo} = p;
            end
            MD_DIV: begin
                if (y == 0) begin
                    m_hi = x;
                    m_lo = '1;
                end else begin
                    q = sx / sy;
                    r = sx % sy;
                    m_lo = q[31:0];
                    m_hi = r[31:0];
                end
            end
            MD_DIVU: begin
                if (y == 0) begin
                    m_hi = x;
                    m_lo = '1;
                end else begin
                    m_lo = x / y;
                    m_hi = x % y;
                end
            end
            MD_MTHI: m_hi = x;
            MD_MTLO: m_lo = x;
            default: ;
        endcase
    endfunction

    // Issue a multi-cycle op and follow it to completion. With inject set, a
    // MULTU start is driven while the op is busy and must be ignored.
    task automatic run_md(input md_op_t o, input logic [31:0] x, input logic [31:0] y, input bit inject);
        int cyc;
        int early;
        model(o, x, y);
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        cyc = 0;
        early = 0;
        while (cyc < 100) begin
            @(negedge clk);
            if (!busy) break;
            cyc++;
            if (done) early++;
            if (inject && cyc == 5) begin
                start = 1'b1; op = MD_MULTU; a = $urandom; b = $urandom;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        chk("busy_cycles", cyc, 33);
        chk("done_while_busy", early, 0);
        chk("done_pulse", 32'(done), 1);
        chk("hi", hi, m_hi);
        chk("lo", lo, m_lo);
        @(negedge clk);
        chk("done_clear", 32'(done), 0);
    endtask

    // Single-cycle ops (MTHI/MTLO/no-op codes).
    task automatic run_mt(input md_op_t o, input logic [31:0] x);
        model(o, x, 0);
        @(negedge clk);
        op = o; a = x; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("mt_hi", hi, m_hi);
        chk("mt_lo", lo, m_lo);
        chk("mt_busy", 32'(busy), 0);
        @(negedge clk);
        chk("mt_done", 32'(done), 0);
        chk("mt_busy_later", 32'(busy), 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        int sel;
        md_op_t ro;
        logic [31:0] ra;
        logic [31:0] rb;

        reset = 1'b0; start = 1'b0; flush = 1'b0; op = MD_NOP; a = '0; b = '0;
        repeat (2) @(negedge clk);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        reset = 1'b1;

        // Directed arithmetic cases
        run_md(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_md(MD_MULT,  32'hFFFF_FFFD, 32'd5,         1'b0);
        run_md(MD_DIV,   32'hFFFF_FFF9, 32'd2,         1'b0);
        run_md(MD_DIVU,  32'd7,         32'd2,         1'b0);
        run_md(MD_DIV,   32'h1234_5678, 32'd0,         1'b0);
        run_md(MD_DIVU,  32'h8765_4321, 32'd0,         1'b0);
        run_md(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_md(MD_MULT,  32'h8000_0000, 32'h8000_0000, 1'b0);

        // Register moves and no-op codes
        run_mt(MD_MTHI, 32'hDEAD_BEEF);
        run_mt(MD_MTLO, 32'h0000_CAFE);
        run_mt(MD_NOP, 32'h1111_1111);
        run_mt(md_op_t'(3'd7), 32'h2222_2222);

        // Start while busy is ignored
        run_md(MD_DIVU, 32'd1000, 32'd7, 1'b1);

        // Flush mid-operation
        @(negedge clk);
        op = MD_DIVU; a = 32'd100; b = 32'd3; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_busy", 32'(busy), 0);
        chk("flush_hi", hi, m_hi);
        chk("flush_lo", lo, m_lo);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        chk("flush_no_done", seen, 0);
        chk("flush_hi_later", hi, m_hi);
        chk("flush_lo_later", lo, m_lo);

        // start together with flush is not accepted
        @(negedge clk);
        op = MD_MULTU; a = $urandom; b = $urandom; start = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; flush = 1'b0;
        chk("sf_busy", 32'(busy), 0);
        @(negedge clk);
        op = MD_MTHI; a = 32'h5555_AAAA; start = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; flush = 1'b0;
        chk("sf_mthi_hi", hi, m_hi);
        chk("sf_busy2", 32'(busy), 0);
        @(negedge clk);
        chk("sf_done", 32'(done), 0);
        chk("sf_lo", lo, m_lo);

        // Randomized mix
        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 3);
            case (sel)
                0: ro = MD_MULT;
                1: ro = MD_MULTU;
                2: ro = MD_DIV;
                default: ro = MD_DIVU;
            endcase
            ra = $urandom;
            rb = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) rb = 32'd0;
            else if (sel == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            else if (sel == 2) rb = $urandom_range(1, 20);
            else if (sel == 3) rb = -$urandom_range(1, 20);
            run_md(ro, ra, rb, 1'b0);
        end

        // Asynchronous reset mid-run
        @(negedge clk);
        op = MD_MULTU; a = 32'hFFFF_0000; b = 32'h1234_5678; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        #1;
        m_hi = '0;
        m_lo = '0;
        chk("arst_hi", hi, 0);
        chk("arst_lo", lo, 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_done", 32'(done), 0);
        @(negedge clk);
        reset = 1'b1;
        run_md(MD_MULTU, 32'd6, 32'd7, 1'b0);
        chk("post_rst_lo", lo, 42);
        chk("post_rst_hi", hi, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers, parametrised in operand width.
- Sits in the execute stage beside the ALU. Replaces the fixed 32-bit HI/LO write path driven by the hien/loen enables.
- Adds multi-cycle MULT/MULTU/DIV/DIVU, MTHI/MTLO, a busy stall handshake to the hazard unit, and a squash (flush) input.

Parameters:
- WIDTH, 32, operand/HI/LO width; legal values are even and >= 4.
- CNT_W, $clog2(WIDTH+1), iteration counter width; derived, never overridden.

Ports:
- clk  in  1  clock, rising-edge.
- reset  in  1  asynchronous, active-low reset; clears all state.
- start  in  1  request to issue op with operands a/b this cycle.
- op  in  3  operation code (package enum md_op_t).
- a  in  WIDTH  rs operand (dividend / multiplicand / MTHI/MTLO source).
- b  in  WIDTH  rt operand (divisor / multiplier).
- flush  in  1  squash: abort in-flight op and ignore a same-cycle start.
- busy  out  1  op in flight; hazard unit stalls MFHI/MFLO and new starts.
- done  out  1  one-cycle pulse in the cycle HI/LO hold a new mul/div result.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; hi=0, lo=0, busy=0, done=0; counter and working registers cleared. Applies at any time, including mid-operation; the in-flight result is lost.
- Ops:
  - MULT/MULTU: {hi,lo} = a*b, 2*WIDTH-bit product, signed or unsigned.
  - DIV/DIVU: lo = quotient, truncated toward zero; hi = remainder, carrying the sign of the dividend.
  - MTHI: hi=a. MTLO: lo=a.
  - Undefined codes: no-op.
- Acceptance: start is taken at a rising edge only when state==IDLE and flush==0. start while busy is ignored; the hazard unit guarantees no such issue. flush with start in the same cycle: the start is ignored.
- MTHI/MTLO: register is written at the accepting edge. No busy, no done.
- FSM states IDLE, RUN, FIX:
  - IDLE -> RUN on accepted mul/div. Latch abs(a), abs(b) for signed ops, raw values for unsigned; latch result sign and remainder sign; count=0.
  - RUN: one radix-2 step per cycle (shift-add multiply or restoring divide). count increments each step. After WIDTH steps -> FIX.
  - FIX: apply sign correction (two's-complement negate of the product/quotient/remainder as required). Write hi/lo at the edge leaving FIX -> IDLE; done=1 for the following cycle only.
- Latency: accepting edge E0; hi/lo update at edge E(WIDTH+1). busy=1 from after E0 until after E(WIDTH+1), i.e. WIDTH+1 cycles. done is high in the cycle after E(WIDTH+1). With WIDTH=32, hi/lo update 33 edges after start.
- flush while busy: next edge returns to IDLE. hi/lo unchanged, done never pulses, busy=0 after that edge.
- Divide by zero (either signedness): hi=a, lo=all ones. Full latency still applies.
- Signed overflow, DIV of most-negative value by -1: lo = most-negative value, hi=0. This falls out of the abs/negate datapath with WIDTH-bit truncation.
- Operands are latched at acceptance; changes to a/b during RUN have no effect.
- hi/lo are stable and readable at all times except at the writing edge.

Decomposition:
- Package muldiv_pkg:
  - md_op_t enum: MD_NOP=0, MD_MULT=1, MD_MULTU=2, MD_DIV=3, MD_DIVU=4, MD_MTHI=5, MD_MTLO=6.
  - md_state_t enum: IDLE, RUN, FIX.
- One natural sub-module: muldiv_step, a combinational single-iteration shift-add/restore-subtract datapath parametrised by WIDTH. The FSM, counter and HI/LO registers stay in muldiv_unit.

Test Plan (WIDTH=32):
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> hi=0xFFFFFFFE lo=0x00000001. busy high exactly 33 cycles; done pulses once in the cycle after the 33rd edge.
- MULT a=-3 b=5 -> hi=0xFFFFFFFF lo=0xFFFFFFF1. DIV a=-7 b=2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF. DIVU a=7 b=2 -> lo=3 hi=1.
- DIV a=0x12345678 b=0 -> hi=0x12345678 lo=0xFFFFFFFF. DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000 hi=0.
- MTHI a=0xDEADBEEF then MTLO a=0x0000CAFE -> hi/lo update on the accepting edge; busy and done stay 0. Start MULTU during a running DIVU -> ignored; DIVU result is correct.
- Start DIVU, assert flush on cycle 10 -> busy=0 after the next edge, hi/lo keep prior values, no done. start+flush in the same cycle -> nothing accepted.
- Drive reset low mid-RUN -> hi=lo=0 and busy=0 immediately (no clock edge). After release, MULTU 6*7 -> lo=42 hi=0.
